admo_ex_stage: RTL
==================

ADMO_EX_STAGE -- requirements
Module: admo_ex_stage

Interface
REQ-001 Parameter: DW, default `DATA_WIDTH (32), operand/result width.
REQ-002 Parameter: RW, default 5, register-address width.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 id_valid  in  1  decode offers an operation; id_ready  out  1  stage accepts it.
REQ-007 id_a, id_b  in  DW  operands; id_op  in  4  ALU opcode; id_rd  in  RW  destination; id_we  in  1  writeback enable.
REQ-008 id_rs_a, id_rs_b  in  RW  source addresses of id_a/id_b (used only with forwarding).
REQ-009 alu_a, alu_b  out  DW; alu_op  out  4  registered operands to combinational ALU.
REQ-010 alu_res  in  DW  combinational ALU result for current alu_a/alu_b/alu_op.
REQ-011 wb_valid  out  1; wb_ready  in  1; wb_data  out  DW; wb_rd  out  RW; wb_we  out  1  writeback handshake.

Function
REQ-012 Two registered slots: X (operands, drives alu_*) and W (result); each with valid bit x_valid/wb_valid.
REQ-013 Transfer id->X when id_valid && id_ready; X->W when x_valid && (!wb_valid || wb_ready); W drains when wb_valid && wb_ready.
REQ-014 id_ready = !x_valid || x_advance (combinational; full throughput, no bubbles when wb_ready held 1).
REQ-015 Latency: op accepted at edge N appears in W with wb_valid=1 after edge N+1 (2 cycles id->wb).
REQ-016 W captures alu_res, x_rd, x_we on X->W transfer; alu_* outputs equal X contents at all times.
REQ-017 Back-pressure: wb_ready=0 with W full and X full holds both slots unchanged, id_ready=0; no data loss or duplication.
REQ-018 Simultaneous drain of W and accept into W and id->X in one cycle all occur; ordering preserved.
REQ-019 X contents stable whenever x_valid && !x_advance; W outputs stable whenever wb_valid && !wb_ready.
REQ-020 Arithmetic wraps modulo 2^DW (performed by ALU; stage adds no width change).
REQ-021 Slot registers hold previous data when not loaded; only valid bits qualify outputs.

Reset
REQ-022 On rst=1 at a clock edge: x_valid=0, wb_valid=0, alu_a=alu_b=0, alu_op=0, wb_data=0, wb_rd=0, wb_we=0.
REQ-023 While rst=1, id_ready=0; in-flight operations are discarded, none emitted after reset.
REQ-024 rst overrides all concurrent handshakes in the same cycle.

Configuration
REQ-025 Macro ADMO_EX_FWD_EN: when defined, operand forwarding is compiled in; when undefined, id_a/id_b enter X unmodified and id_rs_a/id_rs_b are ignored.
REQ-026 With forwarding, per operand: if x_valid && x_we && x_rd==rs && rs!=0 use alu_res; else if wb_valid && wb_we && wb_rd==rs && rs!=0 use wb_data; else id value.
REQ-027 X-slot match has priority over W-slot match; address 0 never forwarded.

Verification
REQ-028 Reset: assert rst 2 cycles mid-traffic -> x_valid=0, wb_valid=0, all data outputs 0, id_ready=0 during rst.
REQ-029 Throughput: wb_ready=1, stream ADD 1+2, SUB 9-4, XOR F0^0F back-to-back -> wb_data 3,5,FF on consecutive cycles starting 2 cycles after first accept.
REQ-030 Stall: W and X full, wb_ready=0 for 5 cycles -> id_ready=0, wb_data/alu_a constant; release -> both results emitted once, in order.
REQ-031 Wrap: ADD FFFFFFFF+1 -> wb_data=0; SUB 0-1 -> wb_data=FFFFFFFF.
REQ-032 ADMO_EX_FWD_EN: ADD rd=3 (5+6) then ADD rs_a=3 id_a=0, id_b=1 next cycle -> second wb_data=12; rd=0 case -> no forwarding, result 1.
REQ-033 Without ADMO_EX_FWD_EN, same sequence as REQ-032 -> second wb_data=1.

Source files
------------

// File: rtl/admo_ex_stage.sv
// admo_ex_stage -- two-slot execute stage between decode and writeback.
//
// Slot X holds the operands that feed an external combinational ALU through
// alu_a/alu_b/alu_op; slot W captures the ALU result for the writeback
// handshake. Both slots are valid/ready pipelined. With writeback always
// ready the stage accepts one operation per cycle and the result appears on
// wb_* two cycles after acceptance.
//
// Optional feature macro: ADMO_EX_FWD_EN
//   defined   : id_a/id_b are replaced by the in-flight result of the
//               youngest producer (X slot first, then W slot) whose rd matches
//               id_rs_a/id_rs_b; register address 0 is never forwarded.
//   undefined : id_a/id_b enter X unmodified; id_rs_a/id_rs_b are ignored.
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   id_valid / id_ready   : decode handshake
//   id_a, id_b, id_op     : operands and ALU opcode
//   id_rd, id_we          : destination register and writeback enable
//   id_rs_a, id_rs_b      : source addresses of id_a/id_b (forwarding only)
//   alu_a, alu_b, alu_op  : registered X-slot contents driving the ALU
//   alu_res               : combinational ALU result for the X slot
//   wb_valid / wb_ready   : writeback handshake
//   wb_data, wb_rd, wb_we : registered W-slot contents

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module admo_ex_stage #(
    parameter int DW = `DATA_WIDTH,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    output logic          id_ready,
    input  logic [DW-1:0] id_a,
    input  logic [DW-1:0] id_b,
    input  logic [3:0]    id_op,
    input  logic [RW-1:0] id_rd,
    input  logic          id_we,
    input  logic [RW-1:0] id_rs_a,
    input  logic [RW-1:0] id_rs_b,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [3:0]    alu_op,
    input  logic [DW-1:0] alu_res,
    output logic          wb_valid,
    input  logic          wb_ready,
    output logic [DW-1:0] wb_data,
    output logic [RW-1:0] wb_rd,
    output logic          wb_we
);

    logic          x_valid;
    logic [RW-1:0] x_rd;
    logic          x_we;
    logic          x_advance;
    logic          id_fire;
    logic [DW-1:0] x_a_next;
    logic [DW-1:0] x_b_next;

    // X moves into W when W is empty or is draining in the same cycle.
    assign x_advance = x_valid && (!wb_valid || wb_ready);
    assign id_ready  = !rst && (!x_valid || x_advance);
    assign id_fire   = id_valid && id_ready;

`ifdef ADMO_EX_FWD_EN
    // The X-slot producer is younger than the W-slot one, so it wins.
    always_comb begin
        x_a_next = id_a;
        if (id_rs_a != '0 && x_valid && x_we && x_rd == id_rs_a)
            x_a_next = alu_res;
        else if (id_rs_a != '0 && wb_valid && wb_we && wb_rd == id_rs_a)
            x_a_next = wb_data;
    end

    always_comb begin
        x_b_next = id_b;
        if (id_rs_b != '0 && x_valid && x_we && x_rd == id_rs_b)
            x_b_next = alu_res;
        else if (id_rs_b != '0 && wb_valid && wb_we && wb_rd == id_rs_b)
            x_b_next = wb_data;
    end
`else
    logic unused_rs;

    assign x_a_next  = id_a;
    assign x_b_next  = id_b;
    assign unused_rs = ^{id_rs_a, id_rs_b};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            x_valid  <= 1'b0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= '0;
            x_rd     <= '0;
            x_we     <= 1'b0;
            wb_valid <= 1'b0;
            wb_data  <= '0;
            wb_rd    <= '0;
            wb_we    <= 1'b0;
        end else begin
            // W slot: load on X->W transfer, otherwise hold; valid clears on drain.
            if (x_advance) begin
                wb_data  <= alu_res;
                wb_rd    <= x_rd;
                wb_we    <= x_we;
                wb_valid <= 1'b1;
            end else if (wb_ready) begin
                wb_valid <= 1'b0;
            end

            // X slot: a new accept overrides the emptying caused by advance.
            if (id_fire) begin
                alu_a   <= x_a_next;
                alu_b   <= x_b_next;
                alu_op  <= id_op;
                x_rd    <= id_rd;
                x_we    <= id_we;
                x_valid <= 1'b1;
            end else if (x_advance) begin
                x_valid <= 1'b0;
            end
        end
    end

endmodule
